// File: rtl/led_pkg.sv
// Shared mode encodings, PWM constants and the per-mode initial LED pattern.
package led_pkg;

  typedef enum logic [2:0] {
    MODE_OFF      = 3'd0,
    MODE_ON       = 3'd1,
    MODE_BLINK    = 3'd2,
    MODE_ROT_L    = 3'd3,
    MODE_ROT_R    = 3'd4,
    MODE_PINGPONG = 3'd5,
    MODE_BREATH   = 3'd6,
    MODE_RSVD     = 3'd7
  } mode_e;

  // Shared by ping-pong (up = toward MSB) and breathing (up = brightening).
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int PWM_W    = 8;
  localparam int DUTY_MAX = 255;
  // Widest LED bank the pattern helper can describe.
  localparam int LED_MAX  = 64;

  // Reserved encoding falls back to OFF so the bank never shows garbage.
  function automatic mode_e map_mode(input logic [2:0] m);
    return (m == 3'd7) ? MODE_OFF : mode_e'(m);
  endfunction

  // Pattern loaded at reset and on every mode change; callers truncate to n bits.
  function automatic logic [LED_MAX-1:0] init_pattern(input mode_e mode, input int n);
    case (mode)
      MODE_ROT_L, MODE_ROT_R, MODE_PINGPONG: return LED_MAX'(1);
      MODE_ON:                               return {LED_MAX{1'b1}} >> (LED_MAX - n);
      default:                               return '0;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Control/status bundle between board logic and one LED bank.
// Handshake: there is no valid/ready pair; en/mode/period_cyc are level
// controls sampled every clock, and tick is a one-cycle strobe marking the
// first cycle of each new step (led already shows that step's pattern).
interface led_pattern_ctrl_if #(
  parameter int LED_NUM = 4,
  parameter int CNT_W   = 28
);
  logic               en;
  logic [2:0]         mode;
  logic [CNT_W-1:0]   period_cyc;
  logic [LED_NUM-1:0] led;
  logic               tick;
  logic [2:0]         mode_cur;

  modport master (output en, mode, period_cyc, input led, tick, mode_cur);
  modport slave  (input en, mode, period_cyc, output led, tick, mode_cur);
endinterface

// File: rtl/led_tick_gen.sv
// Step timebase: counts enabled cycles up to max(period_cyc,1)-1 and emits a
// registered tick on the cycle after each wrap. clear restarts the step.
module led_tick_gen #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] period_cyc,
  output logic             end_cnt,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
  logic             tick_q, tick_d;

  // Terminal count with period 0 clamped to 1; ">=" ends a step at once if the
  // period is lowered below the running count.
  always_comb begin
    last_cnt = (period_cyc == '0) ? '0 : period_cyc - CNT_W'(1);
    end_cnt  = en && (cnt_q >= last_cnt);
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (end_cnt) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: mode tracking, per-step pattern update, breathing duty
// and PWM. The step timebase lives in led_tick_gen.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int LED_NUM   = 4,
  parameter int CNT_W     = 28,
  parameter int RST_MODE  = 3,
  parameter int DUTY_STEP = 8
) (
  input logic               clk,
  input logic               rst_n,
  led_pattern_ctrl_if.slave bus
);

  localparam mode_e              RST_MODE_E = map_mode(3'(RST_MODE));
  localparam logic [LED_NUM-1:0] RST_PAT    = LED_NUM'(init_pattern(RST_MODE_E, LED_NUM));

  mode_e              mode_map, mode_cur_q, mode_cur_d;
  logic               mode_chg, end_cnt, step, tick;
  logic [LED_NUM-1:0] led_q, led_d;
  logic [PWM_W-1:0]   duty_q, duty_d, pwm_q, pwm_d;
  dir_e               dir_q, dir_d;
  logic [PWM_W:0]     duty_up, duty_dn;

  assign mode_map = map_mode(bus.mode);
  assign mode_chg = (mode_map != mode_cur_q);
  // A step coinciding with a mode change is dropped.
  assign step     = end_cnt && !mode_chg;

  led_tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (bus.en),
    .clear      (mode_chg),
    .period_cyc (bus.period_cyc),
    .end_cnt    (end_cnt),
    .tick       (tick)
  );

  // State register: mode, pattern, breathing duty/direction, PWM counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_cur_q <= RST_MODE_E;
      led_q      <= RST_PAT;
      duty_q     <= '0;
      dir_q      <= DIR_UP;
      pwm_q      <= '0;
    end else begin
      mode_cur_q <= mode_cur_d;
      led_q      <= led_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      pwm_q      <= pwm_d;
    end
  end

  // Next state: mode change reloads everything, otherwise apply the step action.
  always_comb begin
    mode_cur_d = mode_cur_q;
    led_d      = led_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    pwm_d      = bus.en ? pwm_q + PWM_W'(1) : pwm_q;
    // 9-bit arithmetic so saturation is visible in the carry/borrow bit.
    duty_up    = {1'b0, duty_q} + (PWM_W+1)'(DUTY_STEP);
    duty_dn    = {1'b0, duty_q} - (PWM_W+1)'(DUTY_STEP);
    if (mode_chg) begin
      mode_cur_d = mode_map;
      led_d      = LED_NUM'(init_pattern(mode_map, LED_NUM));
      duty_d     = '0;
      dir_d      = DIR_UP;
    end else if (mode_cur_q == MODE_BREATH) begin
      if (bus.en) led_d = {LED_NUM{pwm_q < duty_q}};
      if (step) begin
        if (dir_q == DIR_UP) begin
          if (duty_up >= (PWM_W+1)'(DUTY_MAX)) begin
            duty_d = PWM_W'(DUTY_MAX);
            dir_d  = DIR_DOWN;
          end else begin
            duty_d = duty_up[PWM_W-1:0];
          end
        end else begin
          if (duty_dn[PWM_W] || duty_dn == '0) begin
            duty_d = '0;
            dir_d  = DIR_UP;
          end else begin
            duty_d = duty_dn[PWM_W-1:0];
          end
        end
      end
    end else if (step) begin
      case (mode_cur_q)
        MODE_ON:    led_d = '1;
        MODE_BLINK: led_d = ~led_q;
        MODE_ROT_L: led_d = (led_q << 1) | (led_q >> (LED_NUM-1));
        MODE_ROT_R: led_d = (led_q >> 1) | (led_q << (LED_NUM-1));
        MODE_PINGPONG: begin
          if (LED_NUM == 1) begin
            led_d = '1;
          end else if (dir_q == DIR_UP) begin
            if (led_q[LED_NUM-1]) begin
              led_d = led_q >> 1;
              dir_d = DIR_DOWN;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_d = led_q << 1;
              dir_d = DIR_UP;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default:    led_d = '0;
      endcase
    end
  end

  // Outputs: everything is driven straight from registers.
  always_comb begin
    bus.led      = led_q;
    bus.tick     = tick;
    bus.mode_cur = mode_cur_q;
  end

endmodule
